pill_feeder_sim: RTL

Plant model for the bottling controller. It generates the hopper pill-drop waveform (`hopper_level`) and the conveyor status (`conveyor_signal`, `bottle_in_place`) that the controller consumes. It also reacts to the controller's feed-enable and bottle-advance requests. It tracks finite hopper stock, models conveyor travel and stalls, and counts spilled pills, so that the controller's ERROR and FATAL paths are exercisable on the board without real hardware.

---
 rtl/pill_sim_pkg.sv | 20 ++
 rtl/ms_down_timer.sv | 38 +++
 rtl/pill_feeder_sim.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pill_sim_pkg.sv
// Shared types and constants for the pill feeder plant model.
// Holds the dispense/conveyor state encodings and the common timer width.
package pill_sim_pkg;

    localparam int MS_PER_S = 1000;
    localparam int TMR_W    = 11;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_HIGH = 2'd1,
        D_LOW  = 2'd2
    } d_state_e;

    typedef enum logic [1:0] {
        C_IN_PLACE = 2'd0,
        C_MOVING   = 2'd1,
        C_STALLED  = 2'd2
    } c_state_e;

endpackage

// File: rtl/ms_down_timer.sv
// Millisecond down-counter used for the hopper pulse and the conveyor travel.
// Load wins over hold; the count parks at zero once it gets there.
module ms_down_timer
    import pill_sim_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             hold,
    output logic [TMR_W-1:0] count,
    output logic             zero
);

    logic [TMR_W-1:0] count_q;
    logic [TMR_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (!hold && (count_q != '0)) begin
            count_d = count_q - TMR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/pill_feeder_sim.sv
// Plant model for the bottling controller: hopper pill pulses, conveyor travel/stall, stock and spills.
// Optional macro FEEDER_JAM_INJECT_EN adds a jam_inject input that freezes the hopper high phase.
module pill_feeder_sim
    import pill_sim_pkg::*;
#(
    parameter int PILL_PERIOD_MS = 1000,
    parameter int PULSE_HI_MS    = 500,
    parameter int MOVE_MS        = 1500,
    parameter int STOCK_MAX      = 999,
    parameter int STOCK_W        = 10
) (
    input  logic               clk_1khz,
    input  logic               switch_clr,
    input  logic               feed_en,
    input  logic               bottle_switch_req,
    input  logic               refill,
    input  logic               simu_hopper_stop,
    input  logic               simu_hopper_add,
    input  logic               simu_conveyor_stop,
`ifdef FEEDER_JAM_INJECT_EN
    input  logic               jam_inject,
`endif
    output logic               hopper_level,
    output logic               conveyor_signal,
    output logic               bottle_in_place,
    output logic [STOCK_W-1:0] stock,
    output logic               stock_empty,
    output logic [7:0]         spill_cnt
);

    // The low load is one short because the D_IDLE decision cycle completes the pill period.
    localparam int LO_MS = PILL_PERIOD_MS - PULSE_HI_MS - 1;
    localparam logic [TMR_W-1:0] HI_LOAD   = TMR_W'(PULSE_HI_MS);
    localparam logic [TMR_W-1:0] LO_LOAD   = TMR_W'(LO_MS);
    localparam logic [TMR_W-1:0] MOVE_LOAD = TMR_W'(MOVE_MS);
    localparam logic [STOCK_W-1:0] STOCK_FULL = STOCK_W'(STOCK_MAX);

    if (PULSE_HI_MS < 1 || LO_MS < 1 || MOVE_MS < 1) begin : g_bad_zero_load
        $error("pill_feeder_sim: a timer load would be zero");
    end
    if (PULSE_HI_MS > 2 * MS_PER_S || LO_MS > 2 * MS_PER_S || MOVE_MS > 2 * MS_PER_S) begin : g_bad_long_load
        $error("pill_feeder_sim: timer loads are limited to two seconds");
    end
    if ((64'd1 << STOCK_W) <= 64'(STOCK_MAX)) begin : g_bad_stock_w
        $error("pill_feeder_sim: STOCK_W too narrow for STOCK_MAX");
    end

    logic add_meta_q,  add_meta_d;
    logic add_s_q,     add_s_d;
    logic add_prev_q,  add_prev_d;
    logic stop_meta_q, stop_meta_d;
    logic stop_s_q,    stop_s_d;
    logic add_edge;

    d_state_e            d_state_q, d_state_d;
    c_state_e            c_state_q, c_state_d;
    logic [STOCK_W-1:0]  stock_q,   stock_d;
    logic [7:0]          spill_q,   spill_d;

    logic                pulse_load;
    logic [TMR_W-1:0]    pulse_load_val;
    logic                pulse_hold;
    logic [TMR_W-1:0]    pulse_cnt;
    logic                pulse_zero;
    logic                pulse_last;
    logic                drop_start;

    logic                move_load;
    logic                move_hold;
    logic [TMR_W-1:0]    move_cnt;
    logic                move_zero;
    logic                move_last;

    always_comb begin
        add_meta_d  = simu_hopper_add;
        add_s_d     = add_meta_q;
        add_prev_d  = add_s_q;
        stop_meta_d = simu_conveyor_stop;
        stop_s_d    = stop_meta_q;
    end

    assign add_edge = add_s_q & ~add_prev_q;

`ifdef FEEDER_JAM_INJECT_EN
    assign pulse_hold = (d_state_q == D_HIGH) & jam_inject;
`else
    assign pulse_hold = 1'b0;
`endif
    assign move_hold  = stop_s_q;

    // A timer found already at zero also counts as expired so a state can never hang on it.
    assign pulse_last = ~pulse_hold & ((pulse_cnt == TMR_W'(1)) | pulse_zero);
    assign move_last  = ~move_hold  & ((move_cnt  == TMR_W'(1)) | move_zero);

    always_comb begin
        d_state_d      = d_state_q;
        pulse_load     = 1'b0;
        pulse_load_val = HI_LOAD;
        drop_start     = 1'b0;
        case (d_state_q)
            D_IDLE: begin
                if (add_edge || (feed_en && !simu_hopper_stop && !stock_empty)) begin
                    d_state_d  = D_HIGH;
                    pulse_load = 1'b1;
                    drop_start = 1'b1;
                end
            end
            D_HIGH: begin
                if (pulse_last) begin
                    d_state_d      = D_LOW;
                    pulse_load     = 1'b1;
                    pulse_load_val = LO_LOAD;
                end
            end
            D_LOW: begin
                if (pulse_last) begin
                    d_state_d = D_IDLE;
                end
            end
            default: d_state_d = D_IDLE;
        endcase
    end

    // Refill overrides a drop on the same cycle; a drop with no stock never wraps.
    always_comb begin
        stock_d = stock_q;
        spill_d = spill_q;
        if (drop_start && (stock_q != '0)) begin
            stock_d = stock_q - STOCK_W'(1);
        end
        if (refill) begin
            stock_d = STOCK_FULL;
        end
        if (drop_start && !bottle_in_place && (spill_q != 8'hFF)) begin
            spill_d = spill_q + 8'd1;
        end
    end

    always_comb begin
        c_state_d = c_state_q;
        move_load = 1'b0;
        case (c_state_q)
            C_IN_PLACE: begin
                if (bottle_switch_req) begin
                    c_state_d = C_MOVING;
                    move_load = 1'b1;
                end
            end
            C_MOVING: begin
                if (stop_s_q) begin
                    c_state_d = C_STALLED;
                end else if (move_last) begin
                    c_state_d = C_IN_PLACE;
                end
            end
            C_STALLED: begin
                if (!stop_s_q) begin
                    c_state_d = C_MOVING;
                end
            end
            default: c_state_d = C_IN_PLACE;
        endcase
    end

    always_ff @(posedge clk_1khz or posedge switch_clr) begin
        if (switch_clr) begin
            add_meta_q  <= 1'b0;
            add_s_q     <= 1'b0;
            add_prev_q  <= 1'b0;
            stop_meta_q <= 1'b0;
            stop_s_q    <= 1'b0;
            d_state_q   <= D_IDLE;
            c_state_q   <= C_IN_PLACE;
            stock_q     <= STOCK_FULL;
            spill_q     <= 8'd0;
        end else begin
            add_meta_q  <= add_meta_d;
            add_s_q     <= add_s_d;
            add_prev_q  <= add_prev_d;
            stop_meta_q <= stop_meta_d;
            stop_s_q    <= stop_s_d;
            d_state_q   <= d_state_d;
            c_state_q   <= c_state_d;
            stock_q     <= stock_d;
            spill_q     <= spill_d;
        end
    end

    ms_down_timer u_pulse_tmr (
        .clk      (clk_1khz),
        .rst      (switch_clr),
        .load     (pulse_load),
        .load_val (pulse_load_val),
        .hold     (pulse_hold),
        .count    (pulse_cnt),
        .zero     (pulse_zero)
    );

    ms_down_timer u_move_tmr (
        .clk      (clk_1khz),
        .rst      (switch_clr),
        .load     (move_load),
        .load_val (MOVE_LOAD),
        .hold     (move_hold),
        .count    (move_cnt),
        .zero     (move_zero)
    );

    assign hopper_level    = (d_state_q == D_HIGH);
    assign bottle_in_place = (c_state_q == C_IN_PLACE);
    assign conveyor_signal = ~stop_s_q & (c_state_q != C_STALLED);
    assign stock           = stock_q;
    assign stock_empty     = (stock_q == '0);
    assign spill_cnt       = spill_q;

endmodule
